sram_uart_tx_dump: RTL and testbench
====================================

// Module: sram_uart_tx_dump
// PURPOSE
// - Transmit side of the UART/SRAM link: reads a block of 16-bit SRAM words and sends them out UART_TX_O as 8N1 bytes.
// - Dumps decoded/converted image data back to the host, in the same byte order the receive path uses to load SRAM.
// - Sits beside the UART receive interface at top level; top muxes SRAM_address/SRAM_we_n to this block while busy=1.
// PARAMETERS
// - BAUD_DIV      434   clocks per UART bit (50 MHz / 115200)
// - READ_LATENCY  2     cycles from SRAM_address driven to SRAM_read_data valid
// PORTS
// - CLOCK_50_I      in   1   50 MHz clock
// - resetn          in   1   asynchronous, active-low reset
// - start           in   1   1-cycle pulse; begins a dump; ignored while busy=1
// - start_address   in   18  first SRAM word address, sampled on start
// - word_count      in   18  number of 16-bit words to send, sampled on start
// - SRAM_read_data  in   16  SRAM controller read data
// - SRAM_address    out  18  SRAM word address (registered)
// - SRAM_we_n       out  1   write enable; constant 1 (read-only block)
// - UART_TX_O       out  1   serial line, idle high
// - busy            out  1   high from cycle after accepted start until done
// - done            out  1   1-cycle pulse when last stop bit has completed
// BEHAVIOUR
// - Reset: UART_TX_O=1, SRAM_address=0, SRAM_we_n=1, busy=0, done=0, FSM S_TX_IDLE, counters 0.
// - Frame: start bit(0), data bits LSB first, stop bit(1); each bit held exactly BAUD_DIV cycles; frame = 10*BAUD_DIV cycles.
// - Byte order per word: SRAM_read_data[15:8] first, then [7:0].
// - FSM: S_TX_IDLE -> (start, word_count!=0) S_TX_FETCH -> S_TX_WAIT (READ_LATENCY-1 cycles) -> S_TX_LATCH
//   -> S_TX_SEND_HI -> S_TX_SEND_LO -> (words remain) S_TX_SEND_HI with prefetched word | (last) S_TX_DRAIN -> S_TX_IDLE.
// - Prefetch: during S_TX_SEND_LO issue next address and latch its data into a holding register, so the next
//   start bit follows the previous stop bit with a gap of at most 2 clock cycles.
// - Address increments by 1 per word; wraps modulo 2^18 (0x3FFFF -> 0x00000).
// - word_count==0: no SRAM access, line stays high, busy never asserts, done pulses 1 cycle after start.
// - start while busy=1: ignored; in-progress transfer unaffected.
// - done asserts in the cycle after the final stop bit's BAUD_DIV-th cycle; busy deasserts same cycle.
// - Reset mid-transfer: line returns high immediately (async); partial frame abandoned; no done pulse.
// - Serializer handshake: tx_load accepted only when tx_ready=1; tx_ready=0 from load until stop bit complete.
// STRUCTURE
// - Shared header (define_state.h): tx_dump_state_type enum (S_TX_IDLE, S_TX_FETCH, S_TX_WAIT, S_TX_LATCH,
//   S_TX_SEND_HI, S_TX_SEND_LO, S_TX_DRAIN); BAUD_DIV default constant.
// - Sub-module uart_tx_serializer: ports clock, resetn, tx_load, tx_data[7:0], tx_ready, tx_line;
//   owns baud counter, 4-bit bit index, 10-bit shift register.
// - Top level: UART_TX_O driven from this block (replaces constant 1); SRAM mux adds busy term.
// TESTING (bench uses BAUD_DIV=4; SRAM model with 2-cycle read latency)
// - start_address=0x00010, word_count=1, mem[0x10]=0xA55A -> bytes 0xA5 then 0x5A, bits LSB first, each bit 4 cycles, done once.
// - word_count=3, mem=0x1234,0x5678,0x9ABC -> 12 34 56 78 9A BC; inter-frame gap <=2 cycles; total <= 6*40+12 cycles.
// - start_address=0x3FFFF, word_count=2 -> reads 0x3FFFF then 0x00000; SRAM_we_n stays 1 throughout.
// - word_count=0 -> UART_TX_O constant 1, no SRAM address change, done pulse 1 cycle after start, busy stays 0.
// - Second start pulse mid-dump with different address -> ignored; original byte stream unchanged, single done.
// - resetn low during 2nd data bit of a frame -> UART_TX_O=1 immediately, busy=0, no done; fresh start then sends correctly.

Source files
------------

// File: rtl/sram_uart_tx_dump_pkg.sv
// Shared types and defaults for the SRAM-to-UART dump path.
// Holds the dump FSM state encoding and the default UART/SRAM timing constants.
package sram_uart_tx_dump_pkg;

    localparam int BAUD_DIV_DEFAULT     = 434;
    localparam int READ_LATENCY_DEFAULT = 2;
    localparam int ADDR_W               = 18;
    localparam int WORD_W               = 16;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_FETCH,
        S_TX_WAIT,
        S_TX_LATCH,
        S_TX_SEND_HI,
        S_TX_SEND_LO,
        S_TX_DRAIN
    } tx_dump_state_type;

    // Word addresses wrap naturally at the top of the 18-bit SRAM space.
    function automatic logic [ADDR_W-1:0] tx_addr_next(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sram_uart_tx_dump_serializer.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV clocks.
// tx_ready also rises during the last stop-bit cycle so a new byte can follow with no idle gap.
module uart_tx_serializer
    import sram_uart_tx_dump_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_line
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNT_W-1:0] r_baud_cnt;
    logic [3:0]       r_bit_idx;
    logic [9:0]       r_shift;
    logic             r_active;
    logic             w_bit_end;
    logic             w_frame_end;

    assign w_bit_end   = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign w_frame_end = r_active && w_bit_end && (r_bit_idx == 4'd9);
    assign tx_ready    = !r_active || w_frame_end;
    // Bit 0 of the shift register is the line; it rests on the stop bit (or reset ones) when idle.
    assign tx_line     = r_shift[0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_active   <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_idx  <= 4'd0;
            r_shift    <= '1;
        end else if (tx_load && tx_ready) begin
            r_active   <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= 4'd0;
            r_shift    <= {1'b1, tx_data, 1'b0};
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud_cnt <= '0;
                if (r_bit_idx == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_shift   <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_uart_tx_dump.sv
// Reads a block of 16-bit SRAM words and streams them out as UART bytes, high byte first.
// The next word is prefetched while the current low byte is queued so frames run back to back.
module sram_uart_tx_dump
    import sram_uart_tx_dump_pkg::*;
#(
    parameter int BAUD_DIV     = BAUD_DIV_DEFAULT,
    parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [WORD_W-1:0] SRAM_read_data,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_we_n,
    output logic              UART_TX_O,
    output logic              busy,
    output logic              done
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    tx_dump_state_type r_state;
    tx_dump_state_type w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_pf_done;
    logic              r_busy;
    logic              r_done;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_next;

    logic              w_tx_load;
    logic [7:0]        w_tx_data;
    logic              w_tx_ready;
    logic              w_accept;
    logic              w_zero_start;
    logic              w_finish;
    logic              w_last;

    assign w_last       = (r_remaining == ADDR_W'(1));
    assign SRAM_address = r_addr;
    assign SRAM_we_n    = 1'b1;
    assign busy         = r_busy;
    assign done         = r_done;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) r_state <= S_TX_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_tx_load    = 1'b0;
        w_tx_data    = r_word[15:8];
        w_accept     = 1'b0;
        w_zero_start = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_TX_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        w_accept     = 1'b1;
                        w_next_state = S_TX_FETCH;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            S_TX_FETCH: w_next_state = S_TX_WAIT;
            S_TX_WAIT: begin
                if (r_lat_cnt == LAT_W'(READ_LATENCY - 1)) w_next_state = S_TX_LATCH;
            end
            S_TX_LATCH: w_next_state = S_TX_SEND_HI;
            S_TX_SEND_HI: begin
                if (w_tx_ready) begin
                    w_tx_load    = 1'b1;
                    w_next_state = S_TX_SEND_LO;
                end
            end
            S_TX_SEND_LO: begin
                w_tx_data = r_word[7:0];
                // Hold the low byte until the prefetched word has landed, unless this is the last word.
                if (w_tx_ready && (r_pf_done || w_last)) begin
                    w_tx_load    = 1'b1;
                    w_next_state = w_last ? S_TX_DRAIN : S_TX_SEND_HI;
                end
            end
            S_TX_DRAIN: begin
                if (w_tx_ready) begin
                    w_finish     = 1'b1;
                    w_next_state = S_TX_IDLE;
                end
            end
            default: w_next_state = S_TX_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_lat_cnt   <= '0;
            r_pf_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_zero_start || w_finish;
            if (w_accept) begin
                r_busy      <= 1'b1;
                r_addr      <= start_address;
                r_remaining <= word_count;
                r_lat_cnt   <= '0;
            end
            if (w_finish) r_busy <= 1'b0;
            if (r_state == S_TX_FETCH || r_state == S_TX_WAIT) r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            // Issuing the high byte of a non-final word launches the prefetch of the next address.
            if (r_state == S_TX_SEND_HI && w_tx_load && !w_last) begin
                r_addr    <= tx_addr_next(r_addr);
                r_lat_cnt <= '0;
                r_pf_done <= 1'b0;
            end
            if (r_state == S_TX_SEND_LO && !w_last && !r_pf_done) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                if (r_lat_cnt == LAT_W'(READ_LATENCY)) r_pf_done <= 1'b1;
            end
            if (r_state == S_TX_SEND_LO && w_tx_load && !w_last) r_remaining <= r_remaining - ADDR_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (r_state == S_TX_LATCH) r_word <= SRAM_read_data;
        if (r_state == S_TX_SEND_LO && !w_last && !r_pf_done && r_lat_cnt == LAT_W'(READ_LATENCY))
            r_next <= SRAM_read_data;
        if (r_state == S_TX_SEND_LO && w_tx_load && !w_last) r_word <= r_next;
    end

    uart_tx_serializer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_serializer (
        .clock    (CLOCK_50_I),
        .resetn   (resetn),
        .tx_load  (w_tx_load),
        .tx_data  (w_tx_data),
        .tx_ready (w_tx_ready),
        .tx_line  (UART_TX_O)
    );

endmodule

// File: tb/tb_sram_uart_tx_dump.sv
// Directed bench for sram_uart_tx_dump at BAUD_DIV=4 with a 2-cycle-latency SRAM model.
// Serial line is recorded per cycle and decoded into bytes for comparison with hand-computed values.
module tb_sram_uart_tx_dump;

    localparam int B = 4;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [17:0] start_address = '0;
    logic [17:0] word_count = '0;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic        UART_TX_O;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:262143];
    logic [15:0] rd_p1;

    int n_checks = 0;
    int n_fail = 0;

    logic        line_q[$];
    logic [17:0] addr_q[$];
    logic [7:0]  bytes_q[$];
    int done_cnt, done_cyc, busy_hi, busy_gap, busy_at_done, we_bad;
    int fmt_err, max_gap, last_end, low_cnt;

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    always @(posedge CLOCK_50_I) begin
        rd_p1          <= mem[SRAM_address];
        SRAM_read_data <= rd_p1;
    end

    sram_uart_tx_dump #(
        .BAUD_DIV     (B),
        .READ_LATENCY (2)
    ) dut (
        .CLOCK_50_I     (CLOCK_50_I),
        .resetn         (resetn),
        .start          (start),
        .start_address  (start_address),
        .word_count     (word_count),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .UART_TX_O      (UART_TX_O),
        .busy           (busy),
        .done           (done)
    );

    task automatic pulse_start(input logic [17:0] a, input logic [17:0] n);
        @(negedge CLOCK_50_I);
        start_address = a;
        word_count    = n;
        start         = 1'b1;
        @(negedge CLOCK_50_I);
        start = 1'b0;
    endtask

    // Sample index 0 is the first cycle after the start edge.
    task automatic capture(input int max_cyc, input int inj_at, input logic [17:0] inj_addr);
        line_q.delete();
        addr_q.delete();
        done_cnt = 0; done_cyc = -1; busy_hi = 0; busy_gap = 0; busy_at_done = -1; we_bad = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) @(negedge CLOCK_50_I);
            if (c == inj_at) begin
                start_address = inj_addr;
                word_count    = 18'd1;
                start         = 1'b1;
            end else if (c == inj_at + 1) begin
                start = 1'b0;
            end
            line_q.push_back(UART_TX_O);
            if (SRAM_we_n !== 1'b1) we_bad++;
            if (addr_q.size() == 0 || addr_q[addr_q.size()-1] !== SRAM_address) addr_q.push_back(SRAM_address);
            if (busy === 1'b1) busy_hi++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    busy_at_done = (busy === 1'b1) ? 1 : 0;
                end
            end else if (done_cyc < 0 && busy !== 1'b1) begin
                busy_gap++;
            end
        end
    endtask

    task automatic decode();
        int i = 0;
        logic [7:0] v;
        bytes_q.delete();
        fmt_err = 0; max_gap = 0; last_end = -1; low_cnt = 0;
        for (int k = 0; k < line_q.size(); k++) if (line_q[k] !== 1'b1) low_cnt++;
        while (i < line_q.size()) begin
            if (line_q[i] === 1'b0) begin
                if (i + 10*B > line_q.size()) begin
                    fmt_err++;
                    break;
                end
                if (last_end >= 0 && (i - last_end) > max_gap) max_gap = i - last_end;
                for (int b = 0; b < 10; b++)
                    for (int k = 1; k < B; k++)
                        if (line_q[i+B*b+k] !== line_q[i+B*b]) fmt_err++;
                if (line_q[i+9*B] !== 1'b1) fmt_err++;
                for (int b = 0; b < 8; b++) v[b] = line_q[i+B*(b+1)];
                bytes_q.push_back(v);
                i        = i + 10*B;
                last_end = i;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK_50_I);
        n_checks++; if (UART_TX_O !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", UART_TX_O); end
        n_checks++; if (SRAM_address !== 18'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000", SRAM_address); end
        n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", SRAM_we_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50_I);
    endtask

    task automatic test_single_word();
        mem[18'h00010] = 16'hA55A;
        pulse_start(18'h00010, 18'd1);
        capture(110, -1, '0);
        decode();
        n_checks++; if (bytes_q.size() != 2) begin n_fail++; $display("FAIL single_nbytes: got %0d want 2", bytes_q.size()); end
        n_checks++; if (bytes_q.size() < 1 || bytes_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_byte0: got %h want a5", (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx); end
        n_checks++; if (bytes_q.size() < 2 || bytes_q[1] !== 8'h5A) begin n_fail++; $display("FAIL single_byte1: got %h want 5a", (bytes_q.size() > 1) ? bytes_q[1] : 8'hxx); end
        n_checks++; if (fmt_err != 0) begin n_fail++; $display("FAIL single_bit_timing: got %0d errors want 0", fmt_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc != last_end) begin n_fail++; $display("FAIL single_done_timing: done at %0d want %0d", done_cyc, last_end); end
        n_checks++; if (done_cyc < 0 || done_cyc > 2*10*B+12) begin n_fail++; $display("FAIL single_total: done at %0d want <= %0d", done_cyc, 2*10*B+12); end
        n_checks++; if (busy_gap != 0 || busy_at_done != 0) begin n_fail++; $display("FAIL single_busy: low-before-done %0d busy-at-done %0d want 0 0", busy_gap, busy_at_done); end
        n_checks++; if (addr_q.size() != 1 || addr_q[0] !== 18'h00010) begin n_fail++; $display("FAIL single_addr: got %0d addrs first %h want 1 addr 00010", addr_q.size(), addr_q[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        logic [7:0] got;
        mem[18'h00100] = 16'h1234;
        mem[18'h00101] = 16'h5678;
        mem[18'h00102] = 16'h9ABC;
        pulse_start(18'h00100, 18'd3);
        capture(280, -1, '0);
        decode();
        n_checks++; if (bytes_q.size() != 6) begin n_fail++; $display("FAIL b2b_nbytes: got %0d want 6", bytes_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        n_checks++; if (fmt_err != 0) begin n_fail++; $display("FAIL b2b_bit_timing: got %0d errors want 0", fmt_err); end
        n_checks++; if (max_gap > 2) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles want <= 2", max_gap); end
        n_checks++; if (done_cyc < 0 || done_cyc > 6*10*B+12) begin n_fail++; $display("FAIL b2b_total: done at %0d want <= %0d", done_cyc, 6*10*B+12); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (addr_q.size() != 3 || addr_q[0] !== 18'h100 || addr_q[1] !== 18'h101 || addr_q[2] !== 18'h102) begin
            n_fail++; $display("FAIL b2b_addr_seq: got %0d addrs last %h want 100,101,102", addr_q.size(), addr_q[addr_q.size()-1]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] got;
        mem[18'h3FFFF] = 16'hDEAD;
        mem[18'h00000] = 16'hBEEF;
        pulse_start(18'h3FFFF, 18'd2);
        capture(190, -1, '0);
        decode();
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        n_checks++; if (addr_q.size() != 2 || addr_q[0] !== 18'h3FFFF || addr_q[1] !== 18'h00000) begin
            n_fail++; $display("FAIL wrap_addr_seq: got %0d addrs last %h want 3ffff,00000", addr_q.size(), addr_q[addr_q.size()-1]);
        end
        n_checks++; if (we_bad != 0) begin n_fail++; $display("FAIL wrap_we_n: got %0d cycles with we_n!=1 want 0", we_bad); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_count();
        logic [17:0] prev;
        prev = SRAM_address;
        pulse_start(18'h02222, 18'd0);
        capture(20, -1, '0);
        decode();
        n_checks++; if (low_cnt != 0) begin n_fail++; $display("FAIL zero_line: got %0d low cycles want 0", low_cnt); end
        n_checks++; if (done_cyc != 0) begin n_fail++; $display("FAIL zero_done_timing: done at %0d want 0", done_cyc); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (busy_hi != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_hi); end
        n_checks++; if (addr_q.size() != 1 || addr_q[0] !== prev) begin n_fail++; $display("FAIL zero_addr: got %0d addrs first %h want 1 addr %h", addr_q.size(), addr_q[0], prev); end
    endtask

    task automatic test_start_ignored();
        logic [7:0] exp [4] = '{8'h0F, 8'h0F, 8'hC3, 8'hC3};
        logic [7:0] got;
        mem[18'h00200] = 16'h0F0F;
        mem[18'h00201] = 16'hC3C3;
        mem[18'h00300] = 16'h7777;
        pulse_start(18'h00200, 18'd2);
        capture(200, 50, 18'h00300);
        decode();
        n_checks++; if (bytes_q.size() != 4) begin n_fail++; $display("FAIL ignore_nbytes: got %0d want 4", bytes_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL ignore_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (addr_q.size() != 2 || addr_q[0] !== 18'h200 || addr_q[1] !== 18'h201) begin
            n_fail++; $display("FAIL ignore_addr_seq: got %0d addrs last %h want 200,201", addr_q.size(), addr_q[addr_q.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        int stray_done = 0;
        int stray_low = 0;
        mem[18'h00040] = 16'hA55A;
        mem[18'h00041] = 16'h3CC3;
        pulse_start(18'h00040, 18'd1);
        while (UART_TX_O !== 1'b0 && waited < 20) begin
            @(negedge CLOCK_50_I);
            waited++;
        end
        n_checks++; if (UART_TX_O !== 1'b0) begin n_fail++; $display("FAIL rstmid_start_bit: line %b want 0 within 20 cycles", UART_TX_O); end
        // Second cycle of data bit 1; bit 1 of 0xA5 is 0.
        repeat (2*B+1) @(negedge CLOCK_50_I);
        n_checks++; if (UART_TX_O !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit1: line %b want 0", UART_TX_O); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (UART_TX_O !== 1'b1) begin n_fail++; $display("FAIL rstmid_line_async: line %b want 1", UART_TX_O); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        repeat (2) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLOCK_50_I);
            if (done === 1'b1) stray_done++;
            if (UART_TX_O !== 1'b1) stray_low++;
        end
        n_checks++; if (stray_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", stray_done); end
        n_checks++; if (stray_low != 0) begin n_fail++; $display("FAIL rstmid_idle_line: got %0d low cycles want 0", stray_low); end
        pulse_start(18'h00041, 18'd1);
        capture(110, -1, '0);
        decode();
        n_checks++; if (bytes_q.size() != 2 || bytes_q[0] !== 8'h3C || bytes_q[1] !== 8'hC3) begin
            n_fail++; $display("FAIL rstmid_restart: got %0d bytes first %h want 3c c3", bytes_q.size(), (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx);
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rstmid_restart_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_wrap();
        test_zero_count();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
